// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shared 33-bit adder stepped over 32 iterations.
// Optional build macro MULDIV_EARLY_OUT_EN enables 1-cycle zero-operand early-outs.
`timescale 1ns/1ps

module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            annul_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e              r_state;
    state_e              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg;
    logic [XLEN-1:0]     r_result;

    op_e                 w_op;
    logic                w_sign1_op;
    logic                w_sign2_op;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_neg_start;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_fast;
    logic [XLEN-1:0]     w_fast_result;
    logic                w_launch;
    logic                w_iter;
    logic                w_last;

    logic                w_is_div;
    logic [XLEN:0]       w_add_a;
    logic [XLEN:0]       w_add_b;
    logic [XLEN+1:0]     w_sum;
    logic                w_no_borrow;
    logic [2*XLEN-1:0]   w_acc_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_div_sel;
    logic [XLEN-1:0]     w_div_fix;
    logic [XLEN-1:0]     w_final;

    // ---------------- operand preparation at launch ----------------
    assign w_op       = op_e'(op_i);
    assign w_sign1_op = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                        (w_op == OP_DIV)  || (w_op == OP_REM);
    assign w_sign2_op = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_mag1     = (w_sign1_op && reg1_i[XLEN-1]) ? ('0 - reg1_i) : reg1_i;
    assign w_mag2     = (w_sign2_op && reg2_i[XLEN-1]) ? ('0 - reg2_i) : reg2_i;

    always_comb begin
        case (w_op)
            OP_MULH, OP_DIV:   w_neg_start = reg1_i[XLEN-1] ^ reg2_i[XLEN-1];
            OP_MULHSU, OP_REM: w_neg_start = reg1_i[XLEN-1];
            default:           w_neg_start = 1'b0;
        endcase
    end

    assign w_div_zero = op_i[2] && (reg2_i == '0);
    assign w_div_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                        (reg1_i == MIN_NEG) && (reg2_i == '1);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_fast        = 1'b0;
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast        = 1'b1;
            w_fast_result = op_i[1] ? reg1_i : '1;
        end else if (w_div_ovf) begin
            w_fast        = 1'b1;
            w_fast_result = op_i[1] ? '0 : MIN_NEG;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if ((!op_i[2] && ((reg1_i == '0) || (reg2_i == '0))) ||
                 ( op_i[2] &&  (reg1_i == '0) && (reg2_i != '0))) begin
            w_fast        = 1'b1;
            w_fast_result = '0;
        end
`endif
    end

    // ---------------- shared adder and iteration step ----------------
    // Divide uses the carry-out of rem - divisor as "no borrow"; multiply adds the multiplicand when lsb set.
    assign w_is_div = r_op[2];
    assign w_add_a  = w_is_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
    assign w_add_b  = w_is_div ? ~{1'b0, r_a} : (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_is_div};
    assign w_no_borrow = w_sum[XLEN+1];

    always_comb begin
        if (w_is_div) begin
            w_acc_next = {(w_no_borrow ? w_sum[XLEN-1:0] : r_acc[2*XLEN-2:XLEN-1]),
                          r_acc[XLEN-2:0], w_no_borrow};
        end else begin
            w_acc_next = {w_sum[XLEN:0], r_acc[XLEN-1:1]};
        end
    end

    assign w_prod_fix = r_neg ? ('0 - w_acc_next) : w_acc_next;
    assign w_div_sel  = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
    assign w_div_fix  = r_neg ? ('0 - w_div_sel) : w_div_sel;
    assign w_final    = w_is_div           ? w_div_fix :
                        (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] :
                                               w_prod_fix[2*XLEN-1:XLEN];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stallreq_o   = 1'b0;
        w_launch     = 1'b0;
        w_iter       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    stallreq_o   = 1'b1;
                    w_launch     = 1'b1;
                    w_state_next = w_fast ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        w_last       = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (w_launch) begin
            r_cnt <= '0;
            r_op  <= op_i;
            r_a   <= op_i[2] ? w_mag2 : w_mag1;
            r_acc <= {{XLEN{1'b0}}, (op_i[2] ? w_mag1 : w_mag2)};
            r_neg <= w_neg_start;
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if (w_iter) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_next;
            if (w_last) begin
                r_result <= w_final;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == ST_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, control corner cases, random ops vs arithmetic model.
`timescale 1ns/1ps

module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [2:0]  op_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = sa / sb; p = q; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = sa % sb; p = q; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic f;
        f = (op[2] && b == 0) ||
            (((op == 3'd4) || (op == 3'd6)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
        f = f || (!op[2] && (a == 0 || b == 0)) || (op[2] && a == 0 && b != 0);
`endif
        return f;
    endfunction

    // Launch one op in the next cycle and wait (bounded) for the result strobe.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls,
                         output logic stall_at_ready);
        @(negedge clk);
        start_i = 1'b1; op_i = op; reg1_i = a; reg2_i = b;
        stalls = 0;
        #1;
        if (stallreq_o) stalls++;
        @(negedge clk);
        start_i = 1'b0;
        op_i    = 3'($urandom);
        reg1_i  = $urandom;
        reg2_i  = $urandom;
        lat     = 1;
        while (!ready_o && lat < 100) begin
            if (stallreq_o) stalls++;
            @(negedge clk);
            lat++;
        end
        res            = result_o;
        stall_at_ready = stallreq_o;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        int          stalls;
        logic        sr;
        logic        fast;
        fast = is_fast(op, a, b);
        do_op(op, a, b, res, lat, stalls, sr);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), fast ? 32'd1 : 32'd33);
        check({name, " stall in ready cycle"}, {31'b0, sr}, 32'd0);
        if (!fast) check({name, " stall cycles"}, 32'(stalls), 32'd33);
    endtask

    vec_t vecs[16];

    initial begin
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          lat;
        int          stalls;
        int          ready_seen;
        logic        sr;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{3'd0, 32'd0,          32'h1234,      32'd0};
        vecs[13] = '{3'd4, 32'd0,          32'd5,         32'd0};
        vecs[14] = '{3'd1, 32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFF};
        vecs[15] = '{3'd4, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD};

        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
        op_i = 3'd0; reg1_i = 32'd0; reg2_i = 32'd0;
        #12;
        check("reset result_o",   result_o,            32'd0);
        check("reset ready_o",    {31'b0, ready_o},    32'd0);
        check("reset stallreq_o", {31'b0, stallreq_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table, applied back to back.
        for (int i = 0; i < 16; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Result holds in the idle cycle after the strobe.
        @(negedge clk);
        check("hold result_o", result_o, vecs[15].exp);
        check("hold ready_o low", {31'b0, ready_o}, 32'd0);

        // annul_i beats start_i in IDLE.
        start_i = 1'b1; annul_i = 1'b1; op_i = 3'd0; reg1_i = 32'd3; reg2_i = 32'd4;
        #1;
        check("annul-in-idle stall", {31'b0, stallreq_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        check("annul-in-idle no launch stall", {31'b0, stallreq_o}, 32'd0);
        check("annul-in-idle no ready", {31'b0, ready_o}, 32'd0);

        // Annul a MUL at iteration 10, then start DIVU 9/3.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; reg1_i = 32'd123; reg2_i = 32'd456;
        @(negedge clk);
        start_i = 1'b0;
        ready_seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (ready_o) ready_seen++;
            @(negedge clk);
        end
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        if (ready_o) ready_seen++;
        check("annul busy ready_o", {31'b0, ready_o}, 32'd0);
        check("annul busy stall (idle)", {31'b0, stallreq_o}, 32'd0);
        check("annul busy no strobe", 32'(ready_seen), 32'd0);
        run_and_check("post-annul DIVU 9/3", 3'd5, 32'd9, 32'd3, 32'd3);

        // Reset mid-BUSY.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; reg1_i = 32'd1000; reg2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-busy reset result_o", result_o, 32'd0);
        check("mid-busy reset ready_o",  {31'b0, ready_o},    32'd0);
        check("mid-busy reset stall",    {31'b0, stallreq_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ready_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o || stallreq_o) ready_seen++;
        end
        check("after reset stays idle", 32'(ready_seen), 32'd0);

        // Random ops against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: a = 32'd0;
                1: b = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(op, a, b, res, lat, stalls, sr);
            check($sformatf("rand%0d op%0d %h,%h result", i, op, a, b), res, ref_md(op, a, b));
            check($sformatf("rand%0d latency", i), 32'(lat), is_fast(op, a, b) ? 32'd1 : 32'd33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
